// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator: one p/q bit pair per valid cycle,
// result (EQL/LTR) registered and flagged by a one-cycle done pulse.
module serial_comparator #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic p_bit,
  input  logic q_bit,
  output logic busy,
  output logic done,
  output logic EQL,
  output logic LTR
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          eql_q, eql_d;
  logic          ltr_q, ltr_d;
  logic          differ;

  assign differ = p_bit ^ q_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    done_d  = 1'b0;
    eql_d   = eql_q;
    ltr_d   = ltr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          // MSB-first: first difference decides. LSB-first: last difference
          // seen is the most significant one, so it overwrites.
          if (differ && (eq_q || !MSB_FIRST)) begin
            eq_d = 1'b0;
            lt_d = q_bit;
          end
          if (cnt_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            eql_d   = eq_d;
            ltr_d   = lt_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eql_q   <= 1'b0;
      ltr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eql_q   <= eql_d;
      ltr_q   <= ltr_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign EQL  = eql_q;
  assign LTR  = ltr_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: an MSB-first and an LSB-first instance receive
// the same operands (each in its own bit order) and must report the same result.
module tb_serial_comparator;

  logic clk;
  logic reset, start, bit_valid;
  logic pm, qm, pl, ql;
  logic m_busy, m_done, m_eql, m_ltr;
  logic l_busy, l_done, l_eql, l_ltr;

  int total = 0;
  int bad   = 0;

  logic cur_eql, cur_ltr;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] p;
    logic [3:0] q;
    logic [7:0] vpat;
    logic       exp_eql;
    logic       exp_ltr;
  } vec_t;

  vec_t vecs[10];

  serial_comparator #(.W(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .p_bit(pm), .q_bit(qm),
    .busy(m_busy), .done(m_done), .EQL(m_eql), .LTR(m_ltr)
  );

  serial_comparator #(.W(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .p_bit(pl), .q_bit(ql),
    .busy(l_busy), .done(l_done), .EQL(l_eql), .LTR(l_ltr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic eb, input logic ed);
    chk({tag, " msb busy"}, m_busy, eb);
    chk({tag, " msb done"}, m_done, ed);
    chk({tag, " msb EQL"},  m_eql,  cur_eql);
    chk({tag, " msb LTR"},  m_ltr,  cur_ltr);
    chk({tag, " lsb busy"}, l_busy, eb);
    chk({tag, " lsb done"}, l_done, ed);
    chk({tag, " lsb EQL"},  l_eql,  cur_eql);
    chk({tag, " lsb LTR"},  l_ltr,  cur_ltr);
  endtask

  // driver: one full compare; checks are made at negedges, inputs change there too
  task automatic do_compare(input logic [3:0] p, input logic [3:0] q,
                            input logic [7:0] vpat, input bit noise,
                            input logic e_eql, input logic e_ltr,
                            input string tag);
    int nb;
    int k;
    logic v;
    logic [1:0] e;
    @(negedge clk);
    check_out({tag, " idle"}, 1'b0, 1'b0);
    start     = 1'b1;
    bit_valid = 1'b1;
    pm = 1'($urandom); qm = 1'($urandom);
    pl = 1'($urandom); ql = 1'($urandom);
    exp_q.push_back({e_eql, e_ltr});
    nb = 0;
    k  = 0;
    while (nb < 4) begin
      @(negedge clk);
      check_out({tag, " shift"}, 1'b1, 1'b0);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      v = (k < 8) ? vpat[7-k] : 1'b1;
      k++;
      bit_valid = v;
      if (v) begin
        pm = p[3-nb]; qm = q[3-nb];
        pl = p[nb];   ql = q[nb];
        nb++;
      end else begin
        pm = 1'($urandom); qm = 1'($urandom);
        pl = 1'($urandom); ql = 1'($urandom);
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    cur_eql = e[1];
    cur_ltr = e[0];
    check_out({tag, " done"}, 1'b1, 1'b1);
    bit_valid = 1'b0;
    start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b1010, 4'b1011, 8'hFF, 1'b0, 1'b1};
    vecs[1] = '{4'hF,    4'hF,    8'hFF, 1'b1, 1'b0};
    vecs[2] = '{4'b0001, 4'b1000, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{4'h9,    4'h3,    8'b1001_1010, 1'b0, 1'b0};
    vecs[4] = '{4'h0,    4'h0,    8'hFF, 1'b1, 1'b0};
    vecs[5] = '{4'hF,    4'h0,    8'hFF, 1'b0, 1'b0};
    vecs[6] = '{4'h0,    4'hF,    8'hFF, 1'b0, 1'b1};
    vecs[7] = '{4'h8,    4'h7,    8'hFF, 1'b0, 1'b0};
    vecs[8] = '{4'h6,    4'h7,    8'hFF, 1'b0, 1'b1};
    vecs[9] = '{4'h7,    4'h6,    8'b0101_0101, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; bit_valid = 1'b0;
    pm = 1'b0; qm = 1'b0; pl = 1'b0; ql = 1'b0;
    cur_eql = 1'b0; cur_ltr = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 10; i++)
      do_compare(vecs[i].p, vecs[i].q, vecs[i].vpat, 1'b0,
                 vecs[i].exp_eql, vecs[i].exp_ltr, $sformatf("vec%0d", i));

    // reset in the middle of a compare whose predecessor gave EQL=1
    do_compare(4'hF, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b0, "pre_rst");
    @(negedge clk);
    check_out("rst_seq idle", 1'b0, 1'b0);
    start = 1'b1; bit_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_out("rst_seq shift", 1'b1, 1'b0);
      start = 1'b0; bit_valid = 1'b1;
      pm = 1'b1; qm = 1'b0; pl = 1'b1; ql = 1'b0;
    end
    @(negedge clk);
    check_out("rst_seq held", 1'b1, 1'b0);
    bit_valid = 1'b0;
    reset = 1'b1;
    #1;
    cur_eql = 1'b0;
    cur_ltr = 1'b0;
    check_out("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out("post_rst quiet", 1'b0, 1'b0);
    end
    do_compare(4'h5, 4'h5, 8'hFF, 1'b0, 1'b1, 1'b0, "five_five");

    // exhaustive sweep, back-to-back, with start noise during SHIFT/DONE
    for (int p = 0; p < 16; p++)
      for (int q = 0; q < 16; q++)
        do_compare(4'(p), 4'(q), 8'hFF, 1'b1, 1'(p == q), 1'(p < q),
                   $sformatf("sweep p=%0d q=%0d", p, q));

    @(negedge clk);
    start = 1'b0;
    check_out("final idle", 1'b0, 1'b0);
    @(negedge clk);
    check_out("final quiet", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Bit-serial magnitude comparator for unsigned W-bit operands p and q; computes the same EQL/LTR relation as the team's parallel 4-bit comparator.
- Operand bits arrive one pair per valid cycle over a narrow link, in the order set by MSB_FIRST.
- A single-cycle done pulse marks a new result; EQL/LTR hold it until the next compare completes.
- Serves as the serial receive-side counterpart to the parallel comparator and must match it on all 256 operand pairs for W=4.

Parameters:
- W, 4, operand width in bits; legal range 2..16.
- MSB_FIRST, 1, 1 = bits arrive MSB to LSB; 0 = bits arrive LSB to MSB.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begins a compare when sampled high in IDLE.
- bit_valid  input  1  p_bit/q_bit carry a valid operand bit pair this cycle.
- p_bit  input  1  current bit of operand p.
- q_bit  input  1  current bit of operand q.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; EQL/LTR updated in the same cycle.
- EQL  output  1  1 when p == q for the last completed compare.
- LTR  output  1  1 when p < q (unsigned) for the last completed compare.

Behaviour:
- Reset (async, any state, including mid-compare):
  - state = IDLE; bit counter = 0; internal eq = 1, lt = 0.
  - busy = 0, done = 0, EQL = 0, LTR = 0.
  - A partial compare is discarded; no done pulse is issued for it.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - If start = 1 at the clock edge: counter = 0, eq = 1, lt = 0, next state = SHIFT.
  - bit_valid is ignored in IDLE, including in the same cycle as start.
- SHIFT:
  - Each edge with bit_valid = 1 consumes one bit pair and increments the counter.
  - Cycles with bit_valid = 0 stall: no state change and no timeout.
  - start is ignored.
  - MSB_FIRST = 1 update: if eq = 1 and p_bit != q_bit, then eq = 0 and lt = q_bit. The first differing bit is decisive; later bits are still consumed but do not change the result.
  - MSB_FIRST = 0 update: if p_bit != q_bit, then eq = 0 and lt = q_bit, overwriting earlier values. The last differing bit, the most significant one, wins. Equal bits leave eq/lt unchanged.
  - When the bit consumed is number W-1 (counter == W-1 with bit_valid = 1), next state = DONE. The result includes that final bit.
- DONE:
  - Held for exactly one cycle.
  - done = 1, EQL = final eq, LTR = final lt.
  - Next state = IDLE. start sampled during DONE is ignored.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- EQL and LTR:
  - Change only on entry to DONE or on reset.
  - Hold between compares, including while a new compare is in SHIFT.
  - Never both 1.
- Latency:
  - start sampled at edge E0; the first bit can be consumed at E1.
  - With bit_valid held high, the last bit is consumed at E_W and done is high in the cycle after E_W.
  - Minimum start-to-start spacing is W+2 cycles.
- Counter width: clog2(W) bits; it does not wrap within a compare.
- Back-to-back compares: start may be asserted in the first IDLE cycle after DONE.

Test Plan:
- W=4, MSB_FIRST=1, p=4'b1010, q=4'b1011, bit_valid held high -> done pulses 5 cycles after the start edge; EQL=0, LTR=1.
- W=4, MSB_FIRST=1, p=q=4'hF -> EQL=1, LTR=0; busy high for exactly 5 cycles.
- W=4, MSB_FIRST=0, p=4'b0001, q=4'b1000 (bits sent LSB first) -> EQL=0, LTR=1; the LSB difference is overridden by the MSB.
- bit_valid toggling 1,0,0,1,1,0,1 with p=4'h9, q=4'h3 (MSB_FIRST=1) -> exactly 4 bits consumed; done follows the 4th valid; EQL=0, LTR=0.
- reset pulsed after 2 bits of a compare whose previous result was EQL=1 -> EQL=0, LTR=0, busy=0 immediately; no done pulse; a following compare of 5 vs 5 gives EQL=1.
- Exhaustive sweep of all 256 (p,q) pairs, W=4, both MSB_FIRST settings, back-to-back starts -> EQL == (p==q), LTR == (p<q) at every done; start during SHIFT/DONE never changes the result.
